williams_dl_ctrl: RTL
=====================

WILLIAMS_DL_CTRL -- requirements
Module: williams_dl_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning ROM write buffer entries (power of two, >=4).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning clk_sys cycles of core reset held after drain.
REQ-003 SHALL have parameter ROM_AW, default 17, meaning ROM write address width.
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_download  in  1  HPS download active.
REQ-007 ioctl_wr  in  1  one-cycle byte write strobe.
REQ-008 ioctl_addr  in  25  byte address within current download.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 ioctl_index  in  8  download target: 0 ROM, 1 game module id, 254 DIP bank.
REQ-011 ioctl_wait  out  1  back-pressure to HPS.
REQ-012 mem_gnt  in  1  shared ROM/RAM write port free this cycle.
REQ-013 mem_addr  out  ROM_AW  buffered write address.
REQ-014 mem_data  out  8  buffered write data.
REQ-015 mem_we  out  1  one-cycle write strobe.
REQ-016 mod  out  8  game module id.
REQ-017 dips  out  64  DIP bytes; byte n at bits [8n+7:8n].
REQ-018 core_reset  out  1  reset to the game core.
REQ-019 dl_done  out  1  one-cycle pulse on completed load.
REQ-020 ovf  out  1  sticky: ROM byte dropped (out of range or FIFO full).

Function
REQ-021 Index 0 write with ioctl_addr[24:ROM_AW]==0 SHALL push {addr[ROM_AW-1:0], dout} into FIFO; out-of-range SHALL be dropped and set ovf.
REQ-022 Index 1 write SHALL load mod with ioctl_dout on that edge, any address.
REQ-023 Index 254 write with ioctl_addr[24:3]==0 SHALL load dips byte ioctl_addr[2:0]; other addresses ignored.
REQ-024 Writes with any other index SHALL be ignored; index 1/254 writes never enter the FIFO.
REQ-025 Pop SHALL occur on an edge where mem_gnt=1 and FIFO non-empty; mem_addr/mem_data/mem_we are registered, mem_we high exactly the cycle after the pop edge.
REQ-026 Minimum latency ioctl_wr edge to mem_we high SHALL be 1 cycle; entries leave in push order.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; push while full SHALL be dropped (no pop that edge) and set ovf.
REQ-028 ioctl_wait SHALL equal (count >= FIFO_DEPTH-1), decoded from registered count.
REQ-029 FSM states IDLE, LOAD, DRAIN, HOLD; core_reset=1 in all but IDLE.
REQ-030 IDLE->LOAD when ioctl_download=1 and ioctl_index=0.
REQ-031 LOAD->DRAIN when ioctl_download=0.
REQ-032 DRAIN->HOLD when FIFO empty; hold counter cleared on entry.
REQ-033 HOLD->IDLE when counter reaches HOLD_CYCLES-1; dl_done pulses for the first IDLE cycle.
REQ-034 ioctl_download=1 with index 0 in DRAIN or HOLD SHALL return to LOAD, clearing hold counter; FIFO contents preserved.
REQ-035 Index 1/254 downloads SHALL not change FSM state.

Reset
REQ-036 reset asserted SHALL force: state IDLE, FIFO empty, count 0, hold counter 0, mem_we 0, mem_addr 0, mem_data 0, mod 0, dips 0, dl_done 0, ovf 0.
REQ-037 core_reset SHALL be 1 while reset is asserted, then follow FSM state.
REQ-038 reset mid-download SHALL discard buffered bytes; a still-active index-0 download re-enters LOAD the first edge after release.

Structure
REQ-039 State encoding and index constants (0, 1, 254) SHALL live in shared package williams_pkg.
REQ-040 FIFO SHALL be one sub-module, williams_wr_fifo (sync, show-ahead, count output); FSM and decode stay at top.

Verification
REQ-041 mem_gnt=1, write idx0 addr 0x00010 data 0xA5 -> mem_we one cycle later, mem_addr 0x00010, mem_data 0xA5.
REQ-042 mem_gnt=0, 4 idx0 writes -> ioctl_wait=1 after 3rd; 4th accepted; 5th while full dropped, ovf=1; mem_gnt=1 -> 4 strobes in order.
REQ-043 idx0 write addr 0x20000 -> no mem_we, ovf=1; idx254 addr 5 data 0x3C -> dips[47:40]=0x3C; idx254 addr 8 -> dips unchanged.
REQ-044 Download 10 bytes, drop ioctl_download, mem_gnt=1 -> core_reset 1 through drain + 16 cycles, then 0 with dl_done pulse of 1 cycle.
REQ-045 New index-0 download during HOLD -> state LOAD, core_reset stays 1, hold count restarts after next drain.
REQ-046 reset pulse with 3 entries buffered -> mem_we never asserts for them, mod=0, core_reset=1 during reset.

Source files
------------

// File: rtl/williams_pkg.sv
// Shared download-controller types: FSM state encoding and ioctl_index targets.
package williams_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } dl_state_e;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/williams_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; push while full is ignored
// unless a pop happens on the same edge.
module williams_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; only entries behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/williams_dl_ctrl.sv
// HPS ioctl download controller: buffers ROM bytes onto a shared write port,
// captures module id / DIP bytes, and holds the game core in reset while loading.
module williams_dl_ctrl
  import williams_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ROM_AW      = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic              mem_gnt,
  output logic [ROM_AW-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic [7:0]        mod,
  output logic [63:0]       dips,
  output logic              core_reset,
  output logic              dl_done,
  output logic              ovf
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int EW = ROM_AW + 8;

  dl_state_e         state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              dl_done_q, dl_done_d;
  logic              mem_we_q, ovf_q;
  logic [ROM_AW-1:0] mem_addr_q;
  logic [7:0]        mem_data_q, mod_q;
  logic [63:0]       dips_q;

  logic          wr_rom, rom_in_range, push_req, fire, bypass, fifo_pop, fifo_push, drop;
  logic          fifo_empty, fifo_full, restart;
  logic [EW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;

  assign wr_rom       = ioctl_wr && (ioctl_index == IDX_ROM);
  assign rom_in_range = (ioctl_addr[24:ROM_AW] == '0);
  assign push_req     = wr_rom && rom_in_range;
  // An empty buffer with the port granted sends the byte straight out, giving 1-cycle latency.
  assign bypass       = push_req && fifo_empty && mem_gnt;
  assign fifo_pop     = mem_gnt && !fifo_empty;
  assign fire         = fifo_pop || bypass;
  assign fifo_push    = push_req && !bypass;
  assign drop         = fifo_push && fifo_full && !fifo_pop;
  assign restart      = ioctl_download && (ioctl_index == IDX_ROM);

  williams_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .push_i  (fifo_push),
    .din_i   ({ioctl_addr[ROM_AW-1:0], ioctl_dout}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mod_q      <= '0;
      dips_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      mem_we_q <= fire;
      if (fire) begin
        if (fifo_empty) {mem_addr_q, mem_data_q} <= {ioctl_addr[ROM_AW-1:0], ioctl_dout};
        else            {mem_addr_q, mem_data_q} <= fifo_dout;
      end
      if (ioctl_wr && ioctl_index == IDX_MOD) mod_q <= ioctl_dout;
      if (ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
        dips_q[8*ioctl_addr[2:0] +: 8] <= ioctl_dout;
      if ((wr_rom && !rom_in_range) || drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      dl_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      dl_done_q <= dl_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dl_done_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (restart) state_d = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (restart) begin
          state_d = ST_LOAD;
          hold_d  = '0;
        end else if (fifo_empty) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (restart) begin
          state_d = ST_LOAD;
          hold_d  = '0;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          dl_done_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mod        = mod_q;
  assign dips       = dips_q;
  assign ovf        = ovf_q;
  assign dl_done    = dl_done_q;
  assign core_reset = reset || (state_q != ST_IDLE);

endmodule
